// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debouncer:
// channel FSM states, default timing constants, width helper.
package key_debounce_pkg;

   localparam int DEF_NUM_KEYS      = 4;
   localparam int DEF_STABLE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY  = 15000000;
   localparam int DEF_REPEAT_PERIOD = 2500000;

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_HELD         = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   typedef enum logic [1:0] {
      IDLE         = ST_IDLE,
      PRESS_WAIT   = ST_PRESS_WAIT,
      HELD         = ST_HELD,
      RELEASE_WAIT = ST_RELEASE_WAIT
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Bundle of raw buttons and debounced outputs for the debouncer.
// master drives the buttons, slave produces the debounced view.
interface key_debounce_if #(
   parameter int NUM_KEYS = 4
);
   logic [NUM_KEYS-1:0] KEY;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;
   logic [NUM_KEYS-1:0] key_tick;

   modport master (
      output KEY,
      input  key_level,
      input  key_press,
      input  key_release,
      input  key_tick
   );

   modport slave (
      input  KEY,
      output key_level,
      output key_press,
      output key_release,
      output key_tick
   );
endinterface

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop sync, debounce FSM, auto-repeat.
// All outputs come straight from flops.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic tick_o
);

   localparam int MAXC = max3(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int CW   = $clog2(MAXC) + 1;

   localparam logic [CW-1:0] STB_C = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] PER_C = CW'(REPEAT_PERIOD);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [1:0]    sync_q;
   state_e        st_q, st_d;
   logic [CW-1:0] scnt_q, scnt_d;
   logic [CW-1:0] rcnt_q, rcnt_d;
   logic          rph_q, rph_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;
   logic          tick_q, tick_d;

   logic          key_s;
   logic [CW-1:0] rinc;
   logic [CW-1:0] rlim;

   assign key_s = ~sync_q[1];
   assign rinc  = rcnt_q + ONE_C;
   assign rlim  = rph_q ? PER_C : DLY_C;

   always_comb begin
      st_d    = st_q;
      scnt_d  = scnt_q;
      rcnt_d  = rcnt_q;
      rph_d   = rph_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      tick_d  = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (key_s) begin
               st_d   = PRESS_WAIT;
               scnt_d = ONE_C;
            end
         end
         PRESS_WAIT: begin
            if (!key_s) begin
               st_d   = IDLE;
               scnt_d = '0;
            end else if (scnt_q == STB_C) begin
               st_d    = HELD;
               scnt_d  = '0;
               level_d = 1'b1;
               press_d = 1'b1;
               tick_d  = 1'b1;
               rcnt_d  = '0;
               rph_d   = 1'b0;
            end else begin
               scnt_d = scnt_q + ONE_C;
            end
         end
         HELD: begin
            // Repeat counter freezes while a release is being qualified.
            if (!key_s) begin
               st_d   = RELEASE_WAIT;
               scnt_d = ONE_C;
            end else if (rinc == rlim) begin
               tick_d = 1'b1;
               rcnt_d = '0;
               rph_d  = 1'b1;
            end else begin
               rcnt_d = rinc;
            end
         end
         RELEASE_WAIT: begin
            if (key_s) begin
               st_d   = HELD;
               scnt_d = '0;
            end else if (scnt_q == STB_C) begin
               st_d    = IDLE;
               scnt_d  = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
               rcnt_d  = '0;
               rph_d   = 1'b0;
            end else begin
               scnt_d = scnt_q + ONE_C;
            end
         end
         default: begin
            st_d   = IDLE;
            scnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         st_q    <= IDLE;
         scnt_q  <= '0;
         rcnt_q  <= '0;
         rph_q   <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_n_i};
         st_q    <= st_d;
         scnt_q  <= scnt_d;
         rcnt_q  <= rcnt_d;
         rph_q   <= rph_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         tick_q  <= tick_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign tick_o    = tick_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one independent channel per button,
// no arbitration between keys.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int NUM_KEYS      = DEF_NUM_KEYS,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_tick
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk_i     (CLOCK_50),
         .rst_i     (reset),
         .key_n_i   (KEY[i]),
         .level_o   (key_level[i]),
         .press_o   (key_press[i]),
         .release_o (key_release[i]),
         .tick_o    (key_tick[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing parameters.
// Cycle c = outputs observed just after rising edge number c.
module tb_key_debounce;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   key_debounce_if #(.NUM_KEYS(4)) kif ();

   key_debounce #(
      .NUM_KEYS      (4),
      .STABLE_CYCLES (4),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (3)
   ) dut (
      .CLOCK_50    (clk),
      .reset       (rst),
      .KEY         (kif.KEY),
      .key_level   (kif.key_level),
      .key_press   (kif.key_press),
      .key_release (kif.key_release),
      .key_tick    (kif.key_tick)
   );

   always #5 clk = ~clk;

   // {level, press, release, tick}
   function automatic logic [15:0] got();
      return {kif.key_level, kif.key_press,
              kif.key_release, kif.key_tick};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      kif.KEY = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (got() !== 16'h0000) begin
         errors++;
         $display("FAIL reset got=%h exp=%h", got(), 16'h0000);
      end
   endtask

   task automatic test_hold();
      logic [15:0] e;
      do_reset();
      for (int c = 0; c <= 30; c++) begin
         @(negedge clk);
         kif.KEY = 4'b1110;
         @(posedge clk);
         #1;
         e = '0;
         e[12] = (c >= 6);
         e[8]  = (c == 6);
         e[0]  = (c == 6) || (c >= 16 && (c - 16) % 3 == 0);
         checks++;
         if (got() !== e) begin
            errors++;
            $display("FAIL hold cyc=%0d got=%h exp=%h", c, got(), e);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int c = 0; c <= 15; c++) begin
         @(negedge clk);
         kif.KEY = (c < 3) ? 4'b1101 : 4'b1111;
         @(posedge clk);
         #1;
         checks++;
         if (got() !== 16'h0000) begin
            errors++;
            $display("FAIL glitch cyc=%0d got=%h exp=%h", c, got(), 16'h0);
         end
      end
   endtask

   task automatic test_pause();
      logic [15:0] e;
      do_reset();
      for (int c = 0; c <= 33; c++) begin
         @(negedge clk);
         kif.KEY = (c == 20 || c == 21) ? 4'b1111 : 4'b1011;
         @(posedge clk);
         #1;
         e = '0;
         e[14] = (c >= 6);
         e[10] = (c == 6);
         e[2]  = (c == 6) || (c == 16) || (c == 19) ||
                 (c == 25) || (c == 28) || (c == 31);
         checks++;
         if (got() !== e) begin
            errors++;
            $display("FAIL pause cyc=%0d got=%h exp=%h", c, got(), e);
         end
      end
   endtask

   task automatic test_release();
      logic [15:0] e;
      do_reset();
      for (int c = 0; c <= 32; c++) begin
         @(negedge clk);
         kif.KEY = (c < 20) ? 4'b0111 : 4'b1111;
         @(posedge clk);
         #1;
         e = '0;
         e[15] = (c >= 6) && (c <= 25);
         e[11] = (c == 6);
         e[7]  = (c == 26);
         e[3]  = (c == 6) || (c == 16) || (c == 19);
         checks++;
         if (got() !== e) begin
            errors++;
            $display("FAIL release cyc=%0d got=%h exp=%h", c, got(), e);
         end
      end
   endtask

   task automatic test_simul();
      logic [15:0] e;
      do_reset();
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         kif.KEY = 4'b0000;
         @(posedge clk);
         #1;
         e = '0;
         e[15:12] = (c >= 6) ? 4'hF : 4'h0;
         e[11:8]  = (c == 6) ? 4'hF : 4'h0;
         e[3:0]   = (c == 6 || c == 16) ? 4'hF : 4'h0;
         checks++;
         if (got() !== e) begin
            errors++;
            $display("FAIL simul cyc=%0d got=%h exp=%h", c, got(), e);
         end
      end
   endtask

   task automatic test_reset_hold();
      logic [15:0] e;
      do_reset();
      for (int c = 0; c <= 18; c++) begin
         @(negedge clk);
         rst     = (c == 8);
         kif.KEY = 4'b1110;
         @(posedge clk);
         #1;
         e = '0;
         e[12] = (c == 6) || (c == 7) || (c >= 15);
         e[8]  = (c == 6) || (c == 15);
         e[0]  = (c == 6) || (c == 15);
         checks++;
         if (got() !== e) begin
            errors++;
            $display("FAIL rst_hold cyc=%0d got=%h exp=%h", c, got(), e);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      kif.KEY = 4'hF;
      test_reset();
      test_hold();
      test_glitch();
      test_pause();
      test_release();
      test_simul();
      test_reset_hold();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
